// File: rtl/acc_mem_ctrl_if.sv
// Accelerator memory bus: word address, read/write data, request, direction,
// plus the start/finish handshake between the memory controller and the accelerator.
interface acc_mem_ctrl_if;
    logic [15:0] addr;
    logic [31:0] dataW;
    logic [31:0] dataR;
    logic        en;
    logic        we;
    logic        start;
    logic        finish;

    modport master (
        output addr, dataW, en, we, finish,
        input  dataR, start
    );

    modport slave (
        input  addr, dataW, en, we, finish,
        output dataR, start
    );
endinterface

// File: rtl/acc_mem_ctrl.sv
// Image RAM responder for the accelerator: host byte load, start pulse, accelerator service, result dump.
// Optional macro ACC_MEM_PROTECT_EN makes the input-image region read-only to the accelerator.
module acc_mem_ctrl #(
    parameter int MEM_WORDS   = 50688,
    parameter int IMG_WORDS   = 25344,
    parameter int RESULT_BASE = 25344
) (
    input  logic              clk,
    input  logic              reset,
    acc_mem_ctrl_if.slave     acc,
    input  logic              cmd_go,
    input  logic              load_valid,
    input  logic [7:0]        load_data,
    output logic              load_ready,
    output logic              dump_valid,
    output logic [7:0]        dump_data,
    input  logic              dump_ready,
    output logic              busy,
    output logic              err
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(MEM_WORDS + 1);
    localparam logic [CW-1:0] IMG_N    = CW'(IMG_WORDS);
    localparam logic [CW-1:0] IMG_LAST = CW'(IMG_WORDS - 1);
    localparam logic [CW-1:0] RES_BASE = CW'(RESULT_BASE);

    typedef enum logic [2:0] {IDLE, LOAD, KICK, RUN, DUMP} state_t;
    state_t state, state_nx;

    logic [31:0]   mem [MEM_WORDS];

    logic [CW-1:0] word_cnt;
    logic [1:0]    byte_sel;
    logic [23:0]   pack;
    logic          load_fire, load_word, load_done;

    logic          acc_rd, acc_wr, acc_in_range, acc_wr_ok, acc_err;

    logic [CW-1:0] rd_cnt, out_cnt;
    logic [AW-1:0] dump_addr;
    logic          issue_p0, rd_vld_p1, pf_vld_p2;
    logic [31:0]   ram_q_p1, pf_word_p2, out_word;
    logic [1:0]    out_sel;
    logic          out_fire, out_last, out_load, dump_done;

    assign load_fire = (state == LOAD) && load_valid;
    assign load_word = load_fire && (byte_sel == 2'd3);
    assign load_done = load_word && (word_cnt == IMG_LAST);

    assign acc_in_range = ({16'b0, acc.addr} < 32'(MEM_WORDS));
    assign acc_rd = (state == RUN) && acc.en && !acc.we;
    assign acc_wr = (state == RUN) && acc.en && acc.we;
`ifdef ACC_MEM_PROTECT_EN
    assign acc_wr_ok = acc_wr && acc_in_range && ({16'b0, acc.addr} >= 32'(RESULT_BASE));
`else
    assign acc_wr_ok = acc_wr && acc_in_range;
`endif
    assign acc_err = (acc_rd && !acc_in_range) || (acc_wr && !acc_wr_ok);

    // Dump pipeline: issue read (p0) -> RAM output (p1) -> prefetch slot (p2) -> byte shifter
    assign dump_addr = AW'(RES_BASE + rd_cnt);
    assign issue_p0  = (state == DUMP) && (rd_cnt != IMG_N) && !rd_vld_p1 && !pf_vld_p2;
    assign out_fire  = dump_valid && dump_ready;
    assign out_last  = (out_sel == 2'd3);
    assign out_load  = pf_vld_p2 && (!dump_valid || (out_fire && out_last));
    assign dump_done = out_fire && out_last && (out_cnt == IMG_LAST);
    assign dump_data = out_word[7:0];

    always_comb begin
        state_nx   = state;
        load_ready = 1'b0;
        busy       = 1'b1;
        acc.start  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (cmd_go) state_nx = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                if (load_done) state_nx = KICK;
            end
            KICK: begin
                acc.start = 1'b1;
                state_nx  = RUN;
            end
            RUN:  if (acc.finish) state_nx = DUMP;
            DUMP: if (dump_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            word_cnt  <= '0;
            byte_sel  <= '0;
            err       <= 1'b0;
            acc.dataR <= '0;
        end else begin
            state <= state_nx;
            if (state != LOAD) begin
                word_cnt <= '0;
                byte_sel <= '0;
            end else if (load_fire) begin
                byte_sel <= byte_sel + 2'd1;
                if (load_word) word_cnt <= word_cnt + 1'b1;
            end
            if (acc_err) err <= 1'b1;
            if (acc_rd) acc.dataR <= acc_in_range ? mem[acc.addr[AW-1:0]] : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt     <= '0;
            out_cnt    <= '0;
            rd_vld_p1  <= 1'b0;
            pf_vld_p2  <= 1'b0;
            dump_valid <= 1'b0;
            out_word   <= '0;
            out_sel    <= '0;
        end else if (state != DUMP) begin
            rd_cnt     <= '0;
            out_cnt    <= '0;
            rd_vld_p1  <= 1'b0;
            pf_vld_p2  <= 1'b0;
            dump_valid <= 1'b0;
            out_sel    <= '0;
        end else begin
            rd_vld_p1 <= issue_p0;
            if (issue_p0) rd_cnt <= rd_cnt + 1'b1;
            if (rd_vld_p1) pf_vld_p2 <= 1'b1;
            else if (out_load) pf_vld_p2 <= 1'b0;
            if (out_fire && out_last) out_cnt <= out_cnt + 1'b1;
            if (out_load) begin
                out_word   <= pf_word_p2;
                out_sel    <= 2'd0;
                dump_valid <= 1'b1;
            end else if (out_fire) begin
                out_word <= {8'h00, out_word[31:8]};
                out_sel  <= out_sel + 2'd1;
                if (out_last) dump_valid <= 1'b0;
            end
        end
    end

    // RAM array and data-only staging registers carry no reset
    always_ff @(posedge clk) begin
        if (load_fire) pack <= {load_data, pack[23:8]};
        if (load_word) mem[AW'(word_cnt)] <= {load_data, pack};
        else if (acc_wr_ok) mem[acc.addr[AW-1:0]] <= acc.dataW;
        ram_q_p1 <= mem[dump_addr];
        if (rd_vld_p1) pf_word_p2 <= ram_q_p1;
    end
endmodule

// File: tb/tb_acc_mem_ctrl.sv
// Directed bench for acc_mem_ctrl with a scoreboard queue for read data and dump bytes.
module tb_acc_mem_ctrl;
    localparam int MEM_WORDS   = 128;
    localparam int IMG_WORDS   = 32;
    localparam int RESULT_BASE = 64;
    localparam int NBYTES      = IMG_WORDS * 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, cmd_go, load_valid, load_ready, dump_valid, dump_ready, busy, err;
    logic [7:0] load_data, dump_data;

    acc_mem_ctrl_if acc();

    acc_mem_ctrl #(
        .MEM_WORDS(MEM_WORDS), .IMG_WORDS(IMG_WORDS), .RESULT_BASE(RESULT_BASE)
    ) dut (
        .clk(clk), .reset(reset), .acc(acc),
        .cmd_go(cmd_go), .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
        .busy(busy), .err(err)
    );

    int          tests = 0;
    int          failed = 0;
    int          start_cnt = 0;
    logic [31:0] sb_q[$];
    logic [31:0] mdl [MEM_WORDS];
    logic [31:0] last_rd;

    always @(posedge clk) if (acc.start === 1'b1) start_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) begin
            tests++;
            failed++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            check(tag, obs, sb_q.pop_front());
        end
    endtask

    task automatic load_bytes(input int n, input logic [7:0] base);
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        load_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            load_data = base + 8'(i);
            tick();
        end
        load_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a);
        acc.addr = a;
        acc.en   = 1'b1;
        acc.we   = 1'b0;
        last_rd  = (int'(a) < MEM_WORDS) ? mdl[a] : 32'h0;
        sb_q.push_back(last_rd);
        tick();
        sb_check(tag, acc.dataR);
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input bit accepted);
        acc.addr  = a;
        acc.dataW = d;
        acc.en    = 1'b1;
        acc.we    = 1'b1;
        tick();
        acc.en = 1'b0;
        acc.we = 1'b0;
        check("wr_dataR_hold", acc.dataR, last_rd);
        if (accepted) mdl[a] = d;
    endtask

    initial begin
        int nb, stall_bad, idle_cnt;
        bit prev_stall;
        logic [7:0] prev_data;
        bit protect;
`ifdef ACC_MEM_PROTECT_EN
        protect = 1'b1;
`else
        protect = 1'b0;
`endif
        reset = 1'b1; cmd_go = 1'b0; load_valid = 1'b0; load_data = '0; dump_ready = 1'b0;
        acc.addr = '0; acc.dataW = '0; acc.en = 1'b0; acc.we = 1'b0; acc.finish = 1'b0;
        tick();
        tick();
        check("rst_dataR", acc.dataR, 32'h0);
        check("rst_flags", 32'({acc.start, load_ready, dump_valid, busy, err}), 32'h0);
        check("rst_dump_data", 32'(dump_data), 32'h0);
        reset = 1'b0;
        tick();

        // Abort a load after 7 bytes
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        check("load_ready_in_load", 32'({load_ready, busy}), 32'h3);
        load_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            load_data = 8'hA0 + 8'(i);
            tick();
        end
        load_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midload_rst_flags",
              32'({acc.start, load_ready, dump_valid, busy, err}), 32'h0);
        check("midload_rst_data", acc.dataR | 32'(dump_data), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Full frame load, bytes i mod 256
        for (int i = 0; i < NBYTES; i++) mdl[i / 4][8 * (i % 4) +: 8] = 8'(i);
        load_bytes(NBYTES, 8'h00);
        check("start_after_last", 32'({acc.start, load_ready}), 32'h2);
        tick();
        check("start_drop", 32'({acc.start, busy}), 32'h1);

        rd("rd_word0", 16'd0);
        rd("rd_word1", 16'd1);
        acc.en = 1'b0;
        cmd_go = 1'b1;
        tick();
        cmd_go = 1'b0;
        check("cmd_go_ignored", 32'({load_ready, busy}), 32'h1);

        rd("rd_addr5", 16'd5);
        rd("rd_addr6", 16'd6);
        acc.en = 1'b0;
        tick();
        tick();
        check("dataR_hold", acc.dataR, 32'h1B1A1918);

        wr(16'(RESULT_BASE), 32'hDEADBEEF, 1'b1);
        rd("rd_after_wr", 16'(RESULT_BASE));
        acc.en = 1'b0;

        check("err_clear", 32'(err), 32'h0);
        wr(16'd10, 32'h12345678, !protect);
        check("protect_err", 32'(err), 32'(protect));
        rd("rd_addr10", 16'd10);
        rd("rd_out_of_range", 16'd60000);
        acc.en = 1'b0;
        check("range_err", 32'(err), 32'h1);

        for (int k = 0; k < IMG_WORDS; k++)
            wr(16'(RESULT_BASE + k), (k == 0) ? 32'h44332211 : $urandom, 1'b1);
        for (int k = 0; k < IMG_WORDS; k++)
            for (int j = 0; j < 4; j++) sb_q.push_back(32'(mdl[RESULT_BASE + k][8 * j +: 8]));

        // Read request in the same cycle as finish is still served; dump bytes queue behind it
        acc.addr = 16'd1;
        acc.en = 1'b1;
        acc.we = 1'b0;
        acc.finish = 1'b1;
        last_rd = mdl[1];
        sb_q.push_front(last_rd);
        tick();
        sb_check("rd_with_finish", acc.dataR);
        acc.en = 1'b0;
        acc.finish = 1'b0;
        check("busy_in_dump", 32'(busy), 32'h1);

        nb = 0; stall_bad = 0; idle_cnt = 0; prev_stall = 1'b0; prev_data = '0;
        for (int cyc = 0; cyc < 4000 && nb < NBYTES; cyc++) begin
            dump_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            if (prev_stall && (dump_valid !== 1'b1 || dump_data !== prev_data)) stall_bad++;
            if (dump_ready && dump_valid !== 1'b1 && nb > 0) idle_cnt++;
            if (dump_valid === 1'b1 && dump_ready) begin
                sb_check("dump_byte", 32'(dump_data));
                nb++;
            end
            prev_stall = (dump_valid === 1'b1) && !dump_ready;
            prev_data  = dump_data;
            tick();
        end
        dump_ready = 1'b0;
        check("dump_count", 32'(nb), 32'(NBYTES));
        check("dump_stall_stable", 32'(stall_bad), 32'h0);
        check("dump_idle_bound", 32'(idle_cnt <= IMG_WORDS), 32'h1);
        check("dump_end_flags", 32'({dump_valid, busy}), 32'h0);
        check("sb_empty", 32'(sb_q.size()), 32'h0);

        acc.addr = 16'd5;
        acc.en = 1'b1;
        acc.we = 1'b0;
        tick();
        acc.en = 1'b0;
        check("idle_req_ignored", acc.dataR, mdl[1]);
        check("err_sticky", 32'(err), 32'h1);
        check("start_once", 32'(start_cnt), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
